// File: rtl/psum_ofifo.sv
// psum_ofifo: per-column psum FIFOs that re-align the skewed mac_row columns into complete rows.
// Define PSUM_OFIFO_ERR_EN to add the sticky overflow/underflow flags on port err.
module psum_ofifo_col #(
    parameter int psum_bw = 16,
    parameter int depth   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [psum_bw-1:0] din,
    input  logic               wr,
    input  logic               pop,
    output logic [psum_bw-1:0] head,
    output logic               empty,
    output logic               full
);
    localparam int aw = $clog2(depth);

    logic [psum_bw-1:0] mem [depth];
    logic [aw:0]        wr_ptr, rd_ptr;
    logic               push;

    // The extra MSB tells a full FIFO apart from an empty one when the low bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);
    assign push  = wr && (!full || pop);
    assign head  = mem[rd_ptr[aw-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (aw+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (aw+1)'(1);
        end
    end

    // A push while full and popping lands on the slot being vacated this edge.
    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr[aw-1:0]] <= din;
    end
endmodule

module psum_ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_valid,
    output logic [psum_bw*col-1:0] out
`ifdef PSUM_OFIFO_ERR_EN
    ,
    output logic [1:0]             err
`endif
);
    logic [col-1:0][psum_bw-1:0] din, heads;
    logic [col-1:0]              empty, full;
    logic                        pop;

    assign din     = in;
    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop     = rd && o_valid;
    assign out     = o_valid ? heads : '0;

    for (genvar c = 0; c < col; c++) begin : g_col
        psum_ofifo_col #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_col (
            .clk   (clk),
            .reset (reset),
            .din   (din[c]),
            .wr    (wr[c]),
            .pop   (pop),
            .head  (heads[c]),
            .empty (empty[c]),
            .full  (full[c])
        );
    end

`ifdef PSUM_OFIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= '0;
        end else begin
            if (|(wr & full) && !pop) err[0] <= 1'b1;
            if (rd && !o_valid)       err[1] <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_psum_ofifo.sv
// Randomized bench for psum_ofifo against a per-column queue model; covers err when PSUM_OFIFO_ERR_EN is set.
module tb_psum_ofifo;
    localparam int COL   = 8;
    localparam int PW    = 16;
    localparam int DEPTH = 16;
    localparam int W     = PW*COL;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic [W-1:0]   in_i = '0;
    logic [COL-1:0] wr_i = '0;
    logic           rd_i = 1'b0;
    logic           o_full, o_ready, o_valid;
    logic [W-1:0]   dout;
`ifdef PSUM_OFIFO_ERR_EN
    logic [1:0]     err;
`endif

    int n_chk = 0;
    int n_fail = 0;

    logic [PW-1:0]  mq [COL][$];
    logic [1:0]     err_m = '0;

    always #5 clk = ~clk;

    psum_ofifo #(.col(COL), .psum_bw(PW), .depth(DEPTH)) dut (
        .clk     (clk),
        .reset   (rst_i),
        .in      (in_i),
        .wr      (wr_i),
        .rd      (rd_i),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .out     (dout)
`ifdef PSUM_OFIFO_ERR_EN
        ,
        .err     (err)
`endif
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] row(input logic [PW-1:0] v);
        logic [W-1:0] r;
        for (int c = 0; c < COL; c++) r[c*PW +: PW] = v;
        return r;
    endfunction

    // Model of one clock edge using the inputs currently driven.
    task automatic model_step();
        bit valid, pop;
        if (rst_i) begin
            for (int c = 0; c < COL; c++) mq[c].delete();
            err_m = '0;
        end else begin
            valid = 1;
            for (int c = 0; c < COL; c++) if (mq[c].size() == 0) valid = 0;
            pop = rd_i && valid;
            if (rd_i && !valid) err_m[1] = 1'b1;
            for (int c = 0; c < COL; c++) begin
                if (wr_i[c]) begin
                    if (mq[c].size() < DEPTH || pop) mq[c].push_back(in_i[c*PW +: PW]);
                    else err_m[0] = 1'b1;
                end
            end
            if (pop) for (int c = 0; c < COL; c++) void'(mq[c].pop_front());
        end
    endtask

    task automatic compare();
        bit v, f;
        logic [W-1:0] r;
        v = 1; f = 0; r = '0;
        for (int c = 0; c < COL; c++) begin
            if (mq[c].size() == 0) v = 0;
            if (mq[c].size() == DEPTH) f = 1;
        end
        if (v) for (int c = 0; c < COL; c++) r[c*PW +: PW] = mq[c][0];
        chk("o_valid", W'(o_valid), W'(v));
        chk("o_full",  W'(o_full),  W'(f));
        chk("o_ready", W'(o_ready), W'(!f));
        chk("out", dout, r);
`ifdef PSUM_OFIFO_ERR_EN
        chk("err", W'(err), W'(err_m));
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle();
        rst_i = 0; wr_i = '0; rd_i = 0;
    endtask

    logic [W-1:0] saved;

    initial begin
        // Reset held two cycles while writing and reading.
        rst_i = 1; wr_i = '1; rd_i = 1;
        for (int i = 0; i < 2; i++) begin
            in_i = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        chk("rst_valid", W'(o_valid), W'(0));
        chk("rst_ready", W'(o_ready), W'(1));
        chk("rst_out", dout, '0);

        // Skewed fill: column c starts receiving at cycle c.
        idle();
        for (int k = 0; k < COL; k++) begin
            wr_i = COL'((1 << (k+1)) - 1);
            for (int c = 0; c < COL; c++) in_i[c*PW +: PW] = PW'(16'h0100 + c);
            tick();
            if (k == COL-2) chk("skew_notvalid", W'(o_valid), W'(0));
        end
        chk("skew_valid", W'(o_valid), W'(1));
        saved = '0;
        for (int c = 0; c < COL; c++) saved[c*PW +: PW] = PW'(16'h0100 + c);
        chk("skew_row", dout, saved);
        wr_i = '0; rd_i = 1;
        tick();
        chk("skew_drained", W'(o_valid), W'(0));
        rd_i = 0; rst_i = 1;
        tick();

        // Fill to full, overflow drop, drain in order.
        for (int pass = 0; pass < 2; pass++) begin
            idle();
            wr_i = '1;
            for (int n = 0; n < DEPTH; n++) begin
                in_i = row(PW'(n));
                tick();
            end
            chk("full_flag", W'(o_full), W'(1));
            chk("full_ready", W'(o_ready), W'(0));
            if (pass == 0) begin
                in_i = row(16'hDEAD);
                tick();
            end else begin
                rd_i = 1; in_i = row(16'h0020);
                tick();
                chk("rw_full_stays", W'(o_full), W'(1));
            end
            wr_i = '0; rd_i = 1;
            for (int n = 0; n < DEPTH; n++) begin
                if (pass == 0) chk("drain", dout, row(PW'(n)));
                else chk("drain_rw", dout, (n < DEPTH-1) ? row(PW'(n+1)) : row(16'h0020));
                tick();
            end
            chk("drain_empty", W'(o_valid), W'(0));
        end

        // Underflow then a single row.
        idle(); rd_i = 1;
        tick();
        chk("uflow_valid", W'(o_valid), W'(0));
        rd_i = 0; wr_i = '1; in_i = {$urandom, $urandom, $urandom, $urandom}; saved = in_i;
        tick();
        chk("uflow_row", dout, saved);
        wr_i = '0; rd_i = 1;
        tick();

        // Reset with rows buffered.
        idle(); wr_i = '1;
        for (int i = 0; i < 5; i++) begin
            in_i = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        rst_i = 1;
        tick();
        chk("midrst_valid", W'(o_valid), W'(0));
        rst_i = 0; in_i = row(16'h00AA);
        tick();
        chk("midrst_row", dout, row(16'h00AA));

        // Random traffic, alternating fill-biased and drain-biased phases.
        for (int i = 0; i < 3000; i++) begin
            bit fill;
            fill = ((i / 150) % 2) == 0;
            rst_i = ($urandom_range(0, 199) == 0);
            wr_i = fill ? (COL'($urandom) | COL'($urandom)) : (COL'($urandom) & COL'($urandom));
            rd_i = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            in_i = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
